// File: rtl/cnn_pkg.sv
// Shared constants and loader state encoding for the CNN weight/bias loaders.
package cnn_pkg;

    localparam int BIAS_DEPTH = 10;
    localparam int BIAS_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } ld_state_e;

    // Address/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/sp_ram_rf.sv
// Single write port, registered read-first read port. No reset on the array
// or the read register so the storage maps onto block RAM.
module sp_ram_rf #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             re_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Write port; callers guarantee wr_addr_i < DEPTH.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port samples the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (re_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/param_bias_ram.sv
// Bias memory with a serial byte loader and a one-cycle registered read port.
// Bytes are packed little-endian into words and written in ascending order.
//
//   state | meaning
//   IDLE  | after reset, nothing armed; incoming bytes ignored
//   LOAD  | assembling bytes into words, writing each word as it completes
//   FULL  | all DEPTH words written; bytes ignored until the next load_start
module param_bias_ram
    import cnn_pkg::*;
#(
    parameter int  DEPTH  = BIAS_DEPTH,
    parameter int  DATA_W = BIAS_W,
    localparam int AW     = clog2_min1(DEPTH),
    localparam int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              loading,
    output logic              load_done,
    output logic              loaded
);

    localparam int              BW        = clog2_min1(NB);
    localparam logic [AW:0]     DEPTH_L   = (AW + 1)'(DEPTH);
    localparam logic [BW-1:0]   LAST_BYTE = BW'(NB - 1);
    localparam logic [AW-1:0]   LAST_WORD = AW'(DEPTH - 1);

    ld_state_e         state_q;
    logic [BW-1:0]     byte_cnt_q;
    logic [AW-1:0]     word_cnt_q;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_d;
    logic              loading_q;
    logic              load_done_q;
    logic              loaded_q;
    logic              rd_valid_q;
    logic              rd_err_q;
    logic              rd_sel_q;

    logic              byte_take;
    logic              last_byte;
    logic              last_word;
    logic              wr_en;
    logic              rd_in_range;
    logic              ram_re;
    logic [DATA_W-1:0] ram_dout;

    // load_start and rst both swallow a byte arriving in the same cycle.
    assign byte_take   = (state_q == ST_LOAD) && byte_valid && !load_start && !rst;
    assign last_byte   = (byte_cnt_q == LAST_BYTE);
    assign last_word   = (word_cnt_q == LAST_WORD);
    assign wr_en       = byte_take && last_byte;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign ram_re      = rd_en && rd_in_range && !rst;

    // Drop the incoming byte into its lane; on the last lane this is the full word.
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < NB; k++) begin
            if (byte_cnt_q == BW'(k)) begin
                asm_d[8*k +: 8] = byte_in;
            end
        end
    end

    sp_ram_rf #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .we_i      (wr_en),
        .wr_addr_i (word_cnt_q),
        .wr_data_i (asm_d),
        .re_i      (ram_re),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_dout)
    );

    // Loader FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            asm_q       <= '0;
            loading_q   <= 1'b0;
            load_done_q <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            if (load_start) begin
                state_q    <= ST_LOAD;
                byte_cnt_q <= '0;
                word_cnt_q <= '0;
                asm_q      <= '0;
                loading_q  <= 1'b1;
                loaded_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (byte_take) begin
                            if (last_byte) begin
                                byte_cnt_q <= '0;
                                asm_q      <= '0;
                                if (last_word) begin
                                    word_cnt_q  <= '0;
                                    state_q     <= ST_FULL;
                                    loading_q   <= 1'b0;
                                    loaded_q    <= 1'b1;
                                    load_done_q <= 1'b1;
                                end else begin
                                    word_cnt_q <= word_cnt_q + AW'(1);
                                end
                            end else begin
                                byte_cnt_q <= byte_cnt_q + BW'(1);
                                asm_q      <= asm_d;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read status; rd_sel_q remembers whether the held word came from the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_err_q   <= rd_en && !rd_in_range;
            if (rd_en) begin
                rd_sel_q <= rd_in_range;
            end
        end
    end

    assign rd_data   = rd_sel_q ? ram_dout : '0;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign loading   = loading_q;
    assign load_done = load_done_q;
    assign loaded    = loaded_q;

endmodule
